// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transaction sequencer.
// Holds the sequencer state encoding, the command bytes, the burst limit,
// the dummy byte clocked out during reads, and the read-length helper.
package spi_pkg;

  localparam logic [7:0]  CMD_WRITE  = 8'h0A;
  localparam logic [7:0]  CMD_READ   = 8'h0B;
  localparam logic [7:0]  DUMMY_BYTE = 8'h00;
  localparam int unsigned MAX_LEN    = 8;

  typedef enum logic [2:0] {
    ST_SYNC,
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_DRAIN
  } state_e;

  // Data bytes actually transferred: writes are always one byte, reads
  // treat 0 as 1 and saturate at MAX_LEN.
  function automatic logic [3:0] eff_len(input logic rw, input logic [3:0] len);
    logic [3:0] r;
    r = len;
    if (!rw || len == 4'd0) r = 4'd1;
    else if (len > 4'(MAX_LEN)) r = 4'(MAX_LEN);
    return r;
  endfunction

endpackage

// File: rtl/spi_watchdog.sv
// Inactivity watchdog for the SPI sequencer.
// Ports:
//   clk_i     system clock
//   rst_ni    synchronous active-low reset
//   en_i      count while high
//   clear_i   zero the counter (takes priority over counting)
//   expire_o  high in the cycle the count reaches LIMIT-1 and is not cleared,
//             so an enable run of exactly LIMIT cycles trips it
module spi_watchdog #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned LIMIT = 1023
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clear_i,
  output logic expire_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)   cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign expire_o = en_i && !clear_i && (cnt_q == WIDTH'(LIMIT - 1));

endmodule

// File: rtl/spi_controller.sv
// Transaction sequencer in front of the byte-level SPI shift engine.
// One host request becomes command byte, address byte and 1..MAX_LEN data
// bytes inside a single CS-low frame; read bytes are streamed back out.
// Ports:
//   clk, reset (sync, active-low)
//   start/rw/addr/wdata/len   host request (start sampled only when idle)
//   busy/done/error           request status (done/error are 1-cycle pulses)
//   rd_valid/rd_data/rd_index read byte stream
//   spi_enable/spi_data_in    to engine; spi_complete/spi_data_out/spi_cs from engine
module spi_controller
  import spi_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1023,
  parameter int unsigned WD_W           = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  input  logic [3:0] len,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic [2:0] rd_index,
  output logic       spi_enable,
  output logic [7:0] spi_data_in,
  input  logic       spi_complete,
  input  logic [7:0] spi_data_out,
  input  logic       spi_cs
);

  state_e     state_q;
  logic       busy_q, done_q, error_q, rd_valid_q, enable_q, err_flag_q, rw_q;
  logic [7:0] rd_data_q, data_in_q, addr_q, wdata_q;
  logic [2:0] rd_index_q;
  logic [3:0] len_q, remain_q;
  logic       wd_active, wd_clear, wd_expire;
  logic [2:0] idx_w;

  assign wd_active = (state_q == ST_CMD) || (state_q == ST_ADDR) || (state_q == ST_DATA);
  // Every state change out of CMD/ADDR coincides with spi_complete, and
  // IDLE/SYNC/DRAIN hold the counter at zero, so this also clears on entry.
  assign wd_clear  = spi_complete || !wd_active;
  assign idx_w     = 3'(len_q - remain_q);

  spi_watchdog #(
    .WIDTH (WD_W),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wd (
    .clk_i    (clk),
    .rst_ni   (reset),
    .en_i     (wd_active),
    .clear_i  (wd_clear),
    .expire_o (wd_expire)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_SYNC;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_index_q <= '0;
      enable_q   <= 1'b0;
      data_in_q  <= '0;
      err_flag_q <= 1'b0;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      len_q      <= '0;
      remain_q   <= '0;
    end else begin
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      case (state_q)
        ST_SYNC: begin
          if (spi_cs) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (start) begin
            rw_q       <= rw;
            addr_q     <= addr;
            wdata_q    <= wdata;
            len_q      <= eff_len(rw, len);
            err_flag_q <= 1'b0;
            data_in_q  <= rw ? CMD_READ : CMD_WRITE;
            enable_q   <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (spi_complete) begin
            data_in_q <= addr_q;
            state_q   <= ST_ADDR;
          end else if (wd_expire) begin
            enable_q   <= 1'b0;
            err_flag_q <= 1'b1;
            state_q    <= ST_DRAIN;
          end
        end
        ST_ADDR: begin
          if (spi_complete) begin
            data_in_q <= rw_q ? DUMMY_BYTE : wdata_q;
            remain_q  <= len_q;
            state_q   <= ST_DATA;
          end else if (wd_expire) begin
            enable_q   <= 1'b0;
            err_flag_q <= 1'b1;
            state_q    <= ST_DRAIN;
          end
        end
        ST_DATA: begin
          if (spi_complete) begin
            if (rw_q) begin
              rd_valid_q <= 1'b1;
              rd_data_q  <= spi_data_out;
              rd_index_q <= idx_w;
            end
            if (remain_q == 4'd1) begin
              enable_q <= 1'b0;
              state_q  <= ST_DRAIN;
            end else begin
              remain_q  <= remain_q - 4'd1;
              data_in_q <= DUMMY_BYTE;
            end
          end else if (wd_expire) begin
            enable_q   <= 1'b0;
            err_flag_q <= 1'b1;
            state_q    <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (spi_cs) begin
            done_q  <= 1'b1;
            error_q <= err_flag_q;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_SYNC;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
  assign rd_index    = rd_index_q;
  assign spi_enable  = enable_q;
  assign spi_data_in = data_in_q;

endmodule
